// File: rtl/sp_sram_ctrl.sv
// Single-port SRAM controller: zero-fill sweep after reset or clear, then byte-masked
// writes and registered reads. Define SP_SRAM_CTRL_OUT_REG_EN for a 2-cycle read latency.
module sp_sram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  input  logic                  clr_req,
  output logic                  init_done,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {INIT, IDLE} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rerr_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic                  rd_acc;
  logic                  wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic [DATA_WIDTH-1:0] wr_mask_d;

  assign accept   = req_valid && ready_q;
  assign in_range = {1'b0, req_addr} < DEPTH_W;
  assign rd_acc   = accept && req_rw;

  // The sweep owns the write port in INIT; requests are never accepted there.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    wr_mask_d = '0;
    if (state_q == INIT) begin
      wr_en_d   = 1'b1;
      wr_addr_d = cnt_q;
      wr_mask_d = '1;
    end else if (accept && !req_rw && in_range) begin
      wr_en_d   = 1'b1;
      wr_addr_d = req_addr;
      wr_data_d = req_wdata;
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        wr_mask_d[8*i +: 8] = {8{req_be[i]}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem[wr_addr_d] <= (mem[wr_addr_d] & ~wr_mask_d) | (wr_data_d & wr_mask_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= INIT;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
      // Read data is captured at acceptance, so a same-cycle clear still returns old data.
      rvalid_q <= rd_acc;
      rdata_q  <= (rd_acc && in_range) ? mem[req_addr] : '0;
      rerr_q   <= rd_acc && !in_range;
    end
  end

  assign req_ready = ready_q;
  assign init_done = ready_q;

`ifdef SP_SRAM_CTRL_OUT_REG_EN
  logic                  ovalid_q;
  logic [DATA_WIDTH-1:0] odata_q;
  logic                  oerr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      oerr_q   <= 1'b0;
    end else begin
      ovalid_q <= rvalid_q;
      odata_q  <= rdata_q;
      oerr_q   <= rerr_q;
    end
  end

  assign rsp_valid = ovalid_q;
  assign rsp_rdata = odata_q;
  assign rsp_err   = oerr_q;
`else
  assign rsp_valid = rvalid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;
`endif

endmodule

// File: tb/tb_sp_sram_ctrl.sv
// Scoreboard bench for sp_sram_ctrl (DATA_WIDTH=32, DEPTH=24): directed cases then random
// traffic, checked against a word-array reference model.
module tb_sp_sram_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 24;
  localparam int AW    = 5;
  localparam int BW    = 4;
`ifdef SP_SRAM_CTRL_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rw = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be = '0;
  logic          clr_req = 1'b0;
  logic          init_done;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  sp_sram_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .clr_req(clr_req), .init_done(init_done), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] model [DEPTH];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Issue one cycle of stimulus; the model follows the acceptance rules directly.
  task automatic drive(input bit v, input bit rw, input int addr, input logic [DW-1:0] d,
                       input logic [BW-1:0] be, input bit clr);
    exp_t e;
    req_valid = v; req_rw = rw; req_addr = AW'(addr); req_wdata = d; req_be = be; clr_req = clr;
    if (req_ready) begin
      if (v && rw) begin
        e.data = (addr < DEPTH) ? model[addr] : '0;
        e.err  = (addr >= DEPTH);
        e.due  = cyc + LAT;
        q.push_back(e);
      end
      if (v && !rw && addr < DEPTH)
        for (int b = 0; b < BW; b++) if (be[b]) model[addr][8*b +: 8] = d[8*b +: 8];
      if (clr) for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; clr_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input bit pulse_mid, output int n);
    n = 0;
    while (!req_ready && n < 200) begin
      clr_req = pulse_mid && (n == 10);
      @(posedge clk); #1;
      clr_req = 1'b0;
      n++;
    end
  endtask

  initial begin
    int n;
    exp_t e;
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (rsp_valid) begin
            if (q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
              e = q.pop_front();
              check("rsp_rdata", rsp_rdata, e.data);
              check("rsp_err", 32'(rsp_err), 32'(e.err));
              check("rsp_cycle", cyc, e.due);
            end
          end else begin
            check("idle_rdata", rsp_rdata, 0);
            check("idle_err", 32'(rsp_err), 0);
          end
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    #2;
    do_reset();
    wait_ready(1'b0, n);
    check("init_latency", n, 24);
    check("init_done_high", 32'(init_done), 1);

    drive(1, 1, 5, '0, '0, 0);
    drive(1, 0, 3, 32'hDEADBEEF, 4'hF, 0);
    drive(1, 0, 3, 32'h11223344, 4'h5, 0);
    drive(1, 1, 3, '0, '0, 0);
    drive(1, 0, 4, 32'hCAFEF00D, 4'h0, 0);
    drive(1, 1, 4, '0, '0, 0);
    drive(1, 0, 30, 32'hFFFFFFFF, 4'hF, 0);
    drive(1, 1, 24, '0, '0, 0);
    for (int i = 0; i < DEPTH; i++) drive(1, 1, i, '0, '0, 0);
    drive(1, 1, 31, '0, '0, 0);

    drive(1, 0, 7, 32'h12345678, 4'hF, 0);
    drive(1, 1, 7, '0, '0, 1);
    check("clr_ready_low", 32'(req_ready), 0);
    wait_ready(1'b1, n);
    check("clr_sweep_len", n, 24);
    drive(1, 1, 7, '0, '0, 0);
    drive(1, 1, 3, '0, '0, 0);

    drive(0, 0, 0, '0, '0, 1);
    repeat (10) begin @(posedge clk); #1; end
    do_reset();
    wait_ready(1'b0, n);
    check("rst_mid_sweep_len", n, 24);

    for (int k = 0; k < 600; k++) begin
      int a;
      a = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, DEPTH-1)) : int'($urandom_range(0, 31));
      if (req_ready)
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom,
              BW'($urandom_range(0, 15)), $urandom_range(0, 59) == 0);
      else
        drive(0, 0, 0, '0, '0, $urandom_range(0, 7) == 0);
    end

    n = 0;
    while (q.size() != 0 && n < 10) begin @(posedge clk); #1; n++; end
    check("drain_empty", q.size(), 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
